// File: rtl/keccak_chi_row_sched.sv
// keccak_chi_row_sched
//   Sequencer + share compression around one masked Keccak chi S-box of order D.
//   A shared 5-bit row and its fresh masks are taken together in one cycle. The
//   (D+1)^2 cross-share products are registered, then compressed back to D+1
//   shares, and the result is held until downstream takes it.
// Ports
//   clk, rst_i (async, active low), clr (sync abort)
//   in_valid/in_ready, in_a..in_e   : input row shares (bit i = share i)
//   rnd_valid/rnd_ready, rnd        : fresh masks, consumed only with a row
//   out_valid/out_ready, out_a..out_e : compressed output row shares
//   out_idx, out_last               : row tag within the group, last-row flag

// One output bit of masked chi: x0 ^ (~x1 & x2), expanded to (d+1)^2 shares.
// Share (i,j) of the product is registered before any XOR across shares.
module keccak_chi_bit #(
  parameter int d = 2
) (
  input  logic [d:0]               x0,
  input  logic [d:0]               x1,
  input  logic [d:0]               x2,
  input  logic [d*(d+1)/2-1:0]     r,
  output logic [(d+1)*(d+1)-1:0]   xp
);
  localparam int S = d + 1;

  // Negating a shared value: flip share 0 only.
  logic [d:0] nb;
  assign nb = x1 ^ {{d{1'b0}}, 1'b1};

  for (genvar i = 0; i < S; i++) begin : g_i
    for (genvar j = 0; j < S; j++) begin : g_j
      if (i == j) begin : g_diag
        assign xp[i*S+j] = x0[i] ^ (nb[i] & x2[j]);
      end else if (i < j) begin : g_up
        // Pair (i,j) and (j,i) share one mask so the masks cancel on recombination.
        localparam int P = i*S - (i*(i+1))/2 + (j-i-1);
        assign xp[i*S+j] = (nb[i] & x2[j]) ^ r[P];
      end else begin : g_lo
        localparam int P = j*S - (j*(j+1))/2 + (i-j-1);
        assign xp[i*S+j] = (nb[i] & x2[j]) ^ r[P];
      end
    end
  end
endmodule

// Masked chi S-box across a 5-bit row; one keccak_chi_bit per output bit.
module keccak_sbox #(
  parameter int d = 2
) (
  input  logic [d:0]               aa,
  input  logic [d:0]               bb,
  input  logic [d:0]               cc,
  input  logic [d:0]               dd,
  input  logic [d:0]               ee,
  input  logic [5*d*(d+1)/2-1:0]   r,
  output logic [(d+1)*(d+1)-1:0]   ap,
  output logic [(d+1)*(d+1)-1:0]   bp,
  output logic [(d+1)*(d+1)-1:0]   cp,
  output logic [(d+1)*(d+1)-1:0]   dp,
  output logic [(d+1)*(d+1)-1:0]   ep
);
  localparam int RB = d*(d+1)/2;
  localparam int SQ = (d+1)*(d+1);

  logic [4:0][d:0]    row;
  logic [4:0][SQ-1:0] prod;

  assign row = {ee, dd, cc, bb, aa};

  for (genvar k = 0; k < 5; k++) begin : g_bit
    keccak_chi_bit #(.d(d)) u_bit (
      .x0 (row[k]),
      .x1 (row[(k+1)%5]),
      .x2 (row[(k+2)%5]),
      .r  (r[k*RB +: RB]),
      .xp (prod[k])
    );
  end

  assign ap = prod[0];
  assign bp = prod[1];
  assign cp = prod[2];
  assign dp = prod[3];
  assign ep = prod[4];
endmodule

module keccak_chi_row_sched #(
  parameter int D      = 2,
  parameter int N_ROWS = 64,
  localparam int IW    = (N_ROWS > 1) ? $clog2(N_ROWS) : 1
) (
  input  logic                   clk,
  input  logic                   rst_i,
  input  logic                   clr,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [D:0]             in_a,
  input  logic [D:0]             in_b,
  input  logic [D:0]             in_c,
  input  logic [D:0]             in_d,
  input  logic [D:0]             in_e,
  input  logic                   rnd_valid,
  output logic                   rnd_ready,
  input  logic [5*D*(D+1)/2-1:0] rnd,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [D:0]             out_a,
  output logic [D:0]             out_b,
  output logic [D:0]             out_c,
  output logic [D:0]             out_d,
  output logic [D:0]             out_e,
  output logic [IW-1:0]          out_idx,
  output logic                   out_last
);
  localparam int S  = D + 1;
  localparam int SQ = S * S;
  localparam logic [IW-1:0] LAST_IDX = IW'(N_ROWS - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EVAL = 2'd1;
  localparam logic [1:0] ST_OUT  = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [4:0][SQ-1:0]  x_q, x_d;
  logic [4:0][S-1:0]   o_q, o_d;
  logic [IW-1:0]       cnt_q, cnt_d;
  logic [4:0][SQ-1:0]  xp;
  logic [4:0][S-1:0]   comp;
  logic                accept;

  keccak_sbox #(.d(D)) u_sbox (
    .aa (in_a), .bb (in_b), .cc (in_c), .dd (in_d), .ee (in_e),
    .r  (rnd),
    .ap (xp[0]), .bp (xp[1]), .cp (xp[2]), .dp (xp[3]), .ep (xp[4])
  );

  // Compression: output share i of bit k folds row i of the product matrix.
  always_comb begin
    comp = '0;
    for (int k = 0; k < 5; k++)
      for (int i = 0; i < S; i++)
        comp[k][i] = ^x_q[k][i*S +: S];
  end

  always_comb begin
    in_ready  = !clr && ((state_q == ST_IDLE) || ((state_q == ST_OUT) && out_ready));
    accept    = in_valid && in_ready && rnd_valid;
    rnd_ready = accept;
    out_valid = (state_q == ST_OUT);

    state_d = state_q;
    x_d     = accept ? xp : '0;   // products live in x_q for exactly one cycle
    o_d     = o_q;
    cnt_d   = cnt_q;

    case (state_q)
      ST_IDLE: if (accept) state_d = ST_EVAL;
      ST_EVAL: begin
        state_d = ST_OUT;
        o_d     = comp;
      end
      ST_OUT: if (out_ready) state_d = accept ? ST_EVAL : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (out_valid && out_ready)
      cnt_d = (cnt_q == LAST_IDX) ? '0 : cnt_q + IW'(1);

    if (clr) begin
      state_d = ST_IDLE;
      x_d     = '0;
      o_d     = '0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      o_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      o_q     <= o_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_a    = o_q[0];
  assign out_b    = o_q[1];
  assign out_c    = o_q[2];
  assign out_d    = o_q[3];
  assign out_e    = o_q[4];
  assign out_idx  = cnt_q;
  assign out_last = out_valid && (cnt_q == LAST_IDX);
endmodule

// File: tb/tb_keccak_chi_row_sched.sv
module tb_keccak_chi_row_sched;
  localparam int D  = 2;
  localparam int NR = 4;
  localparam int RW = 5*D*(D+1)/2;

  logic clk = 0, rst_i = 0, clr = 0;
  logic in_valid = 0, rnd_valid = 0, out_ready = 1;
  logic in_ready, rnd_ready, out_valid, out_last;
  logic [D:0] in_a = 0, in_b = 0, in_c = 0, in_d = 0, in_e = 0;
  logic [D:0] out_a, out_b, out_c, out_d, out_e;
  logic [RW-1:0] rnd = 0;
  logic [1:0] out_idx;

  int n_cmp = 0, n_err = 0, cyc = 0, acc_cyc = 0;
  logic [4:0] sb[$];
  logic [1:0] exp_idx = 0;

  // Hand-computed chi rows, bit order {e,d,c,b,a}.
  logic [4:0] vin [8] = '{5'b00001, 5'b00000, 5'b11111, 5'b00100,
                          5'b00010, 5'b11000, 5'b00011, 5'b10000};
  logic [4:0] vexp[8] = '{5'b01001, 5'b00000, 5'b11111, 5'b00101,
                          5'b10010, 5'b11010, 5'b01011, 5'b10100};

  keccak_chi_row_sched #(.D(D), .N_ROWS(NR)) dut (
    .clk(clk), .rst_i(rst_i), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d), .in_e(in_e),
    .rnd_valid(rnd_valid), .rnd_ready(rnd_ready), .rnd(rnd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_c(out_c), .out_d(out_d), .out_e(out_e),
    .out_idx(out_idx), .out_last(out_last)
  );

  always #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc = cyc + 1; end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [D:0] shr(input logic b);
    logic [D-1:0] m;
    m = D'($urandom);
    return {m, b ^ (^m)};
  endfunction

  task automatic set_row(input logic [4:0] v);
    in_a = shr(v[0]); in_b = shr(v[1]); in_c = shr(v[2]);
    in_d = shr(v[3]); in_e = shr(v[4]);
    rnd  = RW'($urandom);
  endtask

  // Presents a row and waits for acceptance; valids stay high on return.
  task automatic send_row(input logic [4:0] v, input logic [4:0] e);
    bit ok = 0;
    set_row(v);
    in_valid = 1; rnd_valid = 1;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    chk("accept_timeout", 32'(ok), 1);
    chk("rnd_ready_on_accept", 32'(rnd_ready), 1);
    @(posedge clk);
    sb.push_back(e);
    #1 acc_cyc = cyc;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    in_valid = 0; rnd_valid = 0; out_ready = 1;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (!out_valid && sb.size() == 0) begin ok = 1; break; end
    end
    chk("idle_timeout", 32'(ok), 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_out_valid();
    bit ok = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (out_valid) begin ok = 1; break; end
    end
    chk("out_valid_timeout", 32'(ok), 1);
  endtask

  // Monitor: pops the scoreboard on every output handshake.
  initial forever begin
    logic [4:0] got, e;
    @(negedge clk);
    if (!rst_i || clr) exp_idx = 0;
    else if (out_valid && out_ready) begin
      got = {^out_e, ^out_d, ^out_c, ^out_b, ^out_a};
      if (sb.size() == 0) chk("unexpected_output", 32'(got), 32'hdead);
      else begin
        e = sb.pop_front();
        chk("row_value", 32'(got), 32'(e));
      end
      chk("out_idx", 32'(out_idx), 32'(exp_idx));
      chk("out_last", 32'(out_last), 32'(exp_idx == 2'(NR-1)));
      exp_idx = exp_idx + 2'd1;
    end
  end

  initial begin
    logic [14:0] snap;
    logic [1:0]  snap_idx;
    int prev;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_rnd_ready", 32'(rnd_ready), 0);
    chk("rst_out_last", 32'(out_last), 0);
    chk("rst_out_idx", 32'(out_idx), 0);
    chk("rst_out_shares", 32'({out_a, out_b, out_c, out_d, out_e}), 0);
    @(posedge clk); #1 rst_i = 1;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 1);
    @(posedge clk); #1;

    // Single row with latency check
    send_row(vin[0], vexp[0]);
    in_valid = 0; rnd_valid = 0;
    @(negedge clk);
    chk("lat_eval_no_valid", 32'(out_valid), 0);
    chk("lat_rnd_ready_low", 32'(rnd_ready), 0);
    @(negedge clk);
    chk("lat_out_valid", 32'(out_valid), 1);
    wait_idle();

    // Zero / all-one / c-only rows, 100 random sharings each
    for (int k = 1; k < 4; k++)
      for (int n = 0; n < 100; n++) send_row(vin[k], vexp[k]);
    wait_idle();

    // clr in IDLE with a valid row offered: nothing may be accepted
    set_row(vin[1]); in_valid = 1; rnd_valid = 1; clr = 1;
    @(negedge clk);
    chk("clr_in_ready_low", 32'(in_ready), 0);
    chk("clr_rnd_ready_low", 32'(rnd_ready), 0);
    @(posedge clk); #1 clr = 0;

    // Back-to-back: 8 rows, one every 2 cycles, idx 0..3 twice
    prev = 0;
    for (int k = 0; k < 8; k++) begin
      send_row(vin[k], vexp[k]);
      if (k > 0) chk("b2b_gap", 32'(acc_cyc - prev), 2);
      prev = acc_cyc;
    end
    wait_idle();

    // Backpressure: 5 stalled cycles in OUT, then same-cycle accept
    out_ready = 0;
    send_row(vin[4], vexp[4]);
    set_row(vin[5]);
    @(negedge clk); @(negedge clk);
    chk("bp_out_valid", 32'(out_valid), 1);
    snap = {out_a, out_b, out_c, out_d, out_e};
    snap_idx = out_idx;
    for (int k = 0; k < 5; k++) begin
      chk("bp_shares_stable", 32'({out_a, out_b, out_c, out_d, out_e}), 32'(snap));
      chk("bp_idx_stable", 32'(out_idx), 32'(snap_idx));
      chk("bp_in_ready_low", 32'(in_ready), 0);
      chk("bp_rnd_ready_low", 32'(rnd_ready), 0);
      if (k < 4) @(negedge clk);
    end
    @(posedge clk); #1 out_ready = 1;
    @(negedge clk);
    chk("bp_release_in_ready", 32'(in_ready), 1);
    chk("bp_release_rnd_ready", 32'(rnd_ready), 1);
    @(posedge clk);
    sb.push_back(vexp[5]);
    #1 in_valid = 0; rnd_valid = 0;
    wait_idle();

    // in_valid without rnd_valid for 4 cycles
    set_row(vin[6]); in_valid = 1; rnd_valid = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("nornd_rnd_ready", 32'(rnd_ready), 0);
      chk("nornd_out_valid", 32'(out_valid), 0);
      chk("nornd_state_idle", 32'(dut.state_q), 0);
    end
    @(posedge clk); #1 rnd_valid = 1;
    @(negedge clk);
    chk("nornd_accept", 32'(rnd_ready), 1);
    @(posedge clk);
    sb.push_back(vexp[6]);
    #1 in_valid = 0; rnd_valid = 0;
    wait_idle();

    // clr while in EVAL: row discarded, counter back to 0
    send_row(vin[7], vexp[7]);
    clr = 1;
    @(negedge clk);
    chk("clr_eval_in_ready", 32'(in_ready), 0);
    chk("clr_eval_rnd_ready", 32'(rnd_ready), 0);
    @(posedge clk); #1 clr = 0; in_valid = 0; rnd_valid = 0;
    sb.delete();
    @(negedge clk);
    chk("clr_out_valid", 32'(out_valid), 0);
    chk("clr_shares", 32'({out_a, out_b, out_c, out_d, out_e}), 0);
    chk("clr_xq", 32'(dut.x_q != '0), 0);
    chk("clr_idx", 32'(out_idx), 0);
    @(posedge clk); #1;
    send_row(vin[0], vexp[0]);
    wait_idle();

    // Async reset mid-OUT
    out_ready = 0;
    send_row(vin[3], vexp[3]);
    in_valid = 0; rnd_valid = 0;
    wait_out_valid();
    @(posedge clk); #1 rst_i = 0;
    sb.delete();
    @(negedge clk);
    chk("arst_out_valid", 32'(out_valid), 0);
    chk("arst_shares", 32'({out_a, out_b, out_c, out_d, out_e}), 0);
    chk("arst_xq", 32'(dut.x_q != '0), 0);
    chk("arst_idx", 32'(out_idx), 0);
    chk("arst_out_last", 32'(out_last), 0);
    @(posedge clk); #1 rst_i = 1; out_ready = 1;
    @(negedge clk);
    chk("arst_in_ready", 32'(in_ready), 1);
    @(posedge clk); #1;
    send_row(vin[2], vexp[2]);
    wait_idle();

    chk("scoreboard_drained", 32'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
